// File: rtl/mips_data_ram.sv
// Data memory for the MIPS MEM stage: word RAM behind a one-entry posted write
// buffer with read forwarding, a sticky illegal-access trap and access counters.
module mips_data_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_ren,
  input  logic                 mem_wen,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_din,
  output logic [31:0]          mem_dout,
  output logic                 err,
  output logic [31:0]          err_addr,
  output logic [CNT_WIDTH-1:0] rd_cnt,
  output logic [CNT_WIDTH-1:0] wr_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           data;
  } pend_t;

  logic [31:0]           mem_q [DEPTH];
  pend_t                 pend_q, pend_d;
  logic                  err_q, err_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;

  logic [ADDR_WIDTH-1:0] idx;
  logic                  legal;
  logic                  rd_ok, wr_ok, bad;

  assign idx   = mem_addr[ADDR_WIDTH+1:2];
  assign legal = (mem_addr[1:0] == 2'b00) && (mem_addr[31:ADDR_WIDTH+2] == '0);
  assign rd_ok = mem_ren & legal;
  assign wr_ok = mem_wen & legal;
  assign bad   = (mem_ren | mem_wen) & ~legal;

  // The buffer drains every cycle: a new write simply replaces the entry
  // that is being committed on the same edge.
  always_comb begin
    pend_d = '0;
    if (wr_ok) begin
      pend_d.vld  = 1'b1;
      pend_d.idx  = idx;
      pend_d.data = mem_din;
    end
  end

  always_comb begin
    err_d      = err_q | bad;
    err_addr_d = (bad && !err_q) ? mem_addr : err_addr_q;
    rd_cnt_d   = (rd_ok && rd_cnt_q != '1) ? rd_cnt_q + 1'b1 : rd_cnt_q;
    wr_cnt_d   = (wr_ok && wr_cnt_q != '1) ? wr_cnt_q + 1'b1 : wr_cnt_q;
  end

  // Read sees only older state, so a same-cycle write is not visible yet.
  always_comb begin
    mem_dout = '0;
    if (rd_ok) begin
      if (pend_q.vld && pend_q.idx == idx) mem_dout = pend_q.data;
      else                                 mem_dout = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      pend_q     <= pend_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Array is never cleared; reset only discards an uncommitted entry.
  always_ff @(posedge clk) begin
    if (!rst && pend_q.vld) mem_q[pend_q.idx] <= pend_q.data;
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign rd_cnt   = rd_cnt_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_mips_data_ram.sv
// Bench for mips_data_ram: table of per-cycle vectors plus hand sequences for
// reset-discard and counter saturation; read data checked via an expect queue.
module tb_mips_data_ram;

  localparam int AW = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_ren = 1'b0, mem_wen = 1'b0;
  logic [31:0]   mem_addr = '0, mem_din = '0;
  logic [31:0]   mem_dout;
  logic          err;
  logic [31:0]   err_addr;
  logic [CW-1:0] rd_cnt, wr_cnt;

  int ntests = 0;
  int nfail  = 0;
  logic [31:0] exp_q [$];

  mips_data_ram #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .err(err), .err_addr(err_addr), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_pre;
    logic        ren, wen;
    logic [31:0] addr, din, dout;
    logic [3:0]  rd, wr;
    logic        e;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic rp, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] q, input logic [3:0] rc,
                              input logic [3:0] wc, input logic e,
                              input logic [31:0] ea);
    vec_t v;
    v.rst_pre = rp; v.ren = r; v.wen = w; v.addr = a; v.din = d; v.dout = q;
    v.rd = rc; v.wr = wc; v.e = e; v.ea = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_din = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One request cycle; status outputs reflect state before this cycle's edge.
  task automatic cyc(input string tag, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] q, input logic [3:0] rc,
                     input logic [3:0] wc, input logic e, input logic [31:0] ea);
    logic [31:0] want;
    mem_ren = r; mem_wen = w; mem_addr = a; mem_din = d;
    exp_q.push_back(q);
    @(negedge clk);
    want = exp_q.pop_front();
    check({tag, " dout"}, mem_dout, want);
    check({tag, " rd_cnt"}, 32'(rd_cnt), 32'(rc));
    check({tag, " wr_cnt"}, 32'(wr_cnt), 32'(wc));
    check({tag, " err"}, 32'(err), 32'(e));
    check({tag, " err_addr"}, err_addr, ea);
    @(posedge clk); #1;
  endtask

  initial begin
    // test 1: forward then array
    tbl[0]  = mk(0, 0, 1, 32'h40, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 32'h40, 32'h0,        32'hDEADBEEF, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0,  32'h0,        32'h0,        1, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 32'h40, 32'h0,        32'hDEADBEEF, 1, 1, 0, 0);
    // test 2: back-to-back writes after a reset
    tbl[4]  = mk(1, 0, 1, 32'h0,  32'h11111111, 32'h0,        0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 1, 32'h4,  32'h22222222, 32'h0,        0, 1, 0, 0);
    tbl[6]  = mk(0, 0, 1, 32'h0,  32'h33333333, 32'h0,        0, 2, 0, 0);
    tbl[7]  = mk(0, 1, 0, 32'h0,  32'h0,        32'h33333333, 0, 3, 0, 0);
    tbl[8]  = mk(0, 1, 0, 32'h4,  32'h0,        32'h22222222, 1, 3, 0, 0);
    tbl[9]  = mk(0, 0, 0, 32'h0,  32'h0,        32'h0,        2, 3, 0, 0);
    // test 3: same-cycle read+write returns the old value
    tbl[10] = mk(0, 0, 1, 32'h8,  32'hA5A5A5A5, 32'h0,        2, 3, 0, 0);
    tbl[11] = mk(0, 0, 0, 32'h0,  32'h0,        32'h0,        2, 4, 0, 0);
    tbl[12] = mk(0, 1, 1, 32'h8,  32'h5A5A5A5A, 32'hA5A5A5A5, 2, 4, 0, 0);
    tbl[13] = mk(0, 1, 0, 32'h8,  32'h0,        32'h5A5A5A5A, 3, 5, 0, 0);
    tbl[14] = mk(0, 0, 0, 32'h0,  32'h0,        32'h0,        4, 5, 0, 0);
    // test 4: illegal accesses, first offender kept
    tbl[15] = mk(0, 0, 1, 32'h13, 32'hFFFFFFFF, 32'h0,        4, 5, 0, 0);
    tbl[16] = mk(0, 1, 0, 32'h13, 32'h0,        32'h0,        4, 5, 1, 32'h13);
    tbl[17] = mk(0, 1, 0, 32'h00010000, 32'h0,  32'h0,        4, 5, 1, 32'h13);
    tbl[18] = mk(0, 0, 0, 32'h0,  32'h0,        32'h0,        4, 5, 1, 32'h13);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset err", 32'(err), 32'h0);
    check("reset err_addr", err_addr, 32'h0);
    check("reset rd_cnt", 32'(rd_cnt), 32'h0);
    check("reset wr_cnt", 32'(wr_cnt), 32'h0);

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].rst_pre) do_reset();
      cyc($sformatf("vec%0d", i), tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].din,
          tbl[i].dout, tbl[i].rd, tbl[i].wr, tbl[i].e, tbl[i].ea);
    end

    // test 5: reset on the edge after a write discards the pending entry
    do_reset();
    cyc("t5 w1",   0, 1, 32'h20, 32'h1, 32'h0, 0, 0, 0, 0);
    cyc("t5 idle", 0, 0, 32'h0,  32'h0, 32'h0, 0, 1, 0, 0);
    cyc("t5 idle", 0, 0, 32'h0,  32'h0, 32'h0, 0, 1, 0, 0);
    cyc("t5 w2",   0, 1, 32'h20, 32'h2, 32'h0, 0, 1, 0, 0);
    do_reset();
    cyc("t5 rd",   1, 0, 32'h20, 32'h0, 32'h1, 0, 0, 0, 0);

    // test 6: read counter saturates at all-ones
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc($sformatf("t6 rd%0d", i), 1, 0, 32'h20, 32'h0, 32'h1,
          (i > 15) ? 4'hF : 4'(i), 0, 0, 0);
    cyc("t6 hold", 0, 0, 32'h0, 32'h0, 32'h0, 4'hF, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
